// File: rtl/mbm_pkg.sv
// Shared definitions for the minimally-biased-multiplier datapath:
// FSM state encoding, default operand width, counter width and rounding bias.
package mbm_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);
  localparam int ROUND_BIAS    = 1 << (DEFAULT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } mbm_state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder shared by the multiplier's accumulate and rounding steps.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with start/done handshake.
// Define MBM_ROUND_EN to add a ROUND state that returns round-half-up of product/2^WIDTH.
module shift_add_multiplier
  import mbm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mbm_state_t state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Adder input mux: CALC adds the multiplicand when the multiplier LSB is set;
  // ROUND adds only the rounding bit taken from the top of the low half.
  always_comb begin
    add_a   = acc_q;
    add_b   = q_q[0] ? m_q : '0;
    add_cin = 1'b0;
`ifdef MBM_ROUND_EN
    if (state_q == ROUND) begin
      add_b   = '0;
      add_cin = q_q[WIDTH-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Carry-out becomes the new accumulator MSB so nothing is dropped.
        {acc_d, q_d} = {add_cout, add_s, q_q[WIDTH-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef MBM_ROUND_EN
          state_d = ROUND;
`else
          p_d     = {add_cout, add_s, q_q[WIDTH-1:1]};
          state_d = DONE;
`endif
        end
      end
      ROUND: begin
        p_d     = {add_s, {WIDTH{1'b0}}};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed scoreboard bench for shift_add_multiplier (exact or MBM_ROUND_EN build).
module tb_shift_add_multiplier;
  import mbm_pkg::*;

  localparam int W = 8;
`ifdef MBM_ROUND_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int checks;
  int errors;
  int edge_cnt;
  int e0_edge;
  int done_pulses;
  int pulses_before;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] pr;
    pr = (2*W)'(x) * (2*W)'(y);
`ifdef MBM_ROUND_EN
    pr = (2*W)'(((32'(pr) + ROUND_BIAS) >> W) << W);
`endif
    return pr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi);
    exp_q.push_back(model(ai, bi));
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0_edge = edge_cnt;
  endtask

  task automatic wait_done(input string tag);
    logic [2*W-1:0] expv;
    while (done !== 1'b1 && (edge_cnt - e0_edge) < 40) begin
      @(posedge clk);
      #1;
    end
    chk({tag, " latency"}, 32'(edge_cnt - e0_edge), 32'(LAT));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else expv = 'x;
    chk({tag, " p"}, 32'(p), 32'(expv));
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " done_low"}, 32'(done), 32'd0);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_cnt = 0;
    e0_edge = 0;
    done_pulses = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset p", 32'(p), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    launch(8'h00, 8'h01);
    wait_done("zero");
    after_done("zero");

    launch(8'hFF, 8'hFF);
    wait_done("max");
    after_done("max");

    launch(8'h40, 8'h28);
    wait_done("mid");
    after_done("mid");

    launch(8'h80, 8'h01);
    wait_done("half");
    after_done("half");

    pulses_before = done_pulses;
    launch(8'h22, 8'h60);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore");
    after_done("ignore");
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("ignore single_pulse", 32'(done_pulses - pulses_before), 32'd1);
    chk("ignore idle", 32'(busy), 32'd0);

    pulses_before = done_pulses;
    launch(8'hA4, 8'h42);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort p", 32'(p), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("abort no_pulse", 32'(done_pulses - pulses_before), 32'd0);
    chk("abort p_held", 32'(p), 32'd0);
    launch(8'hA4, 8'h42);
    wait_done("reissue");
    after_done("reissue");

    exp_q.push_back(model(8'h03, 8'h05));
    exp_q.push_back(model(8'h03, 8'h05));
    @(negedge clk);
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0_edge = edge_cnt;
    wait_done("hold1");
    @(posedge clk);
    #1;
    chk("hold idle_gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("hold reaccept", 32'(busy), 32'd1);
    e0_edge = edge_cnt;
    start = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    wait_done("hold2");
    after_done("hold2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

- Sequential unsigned WIDTH×WIDTH shift-add multiplier for the minimally-biased-multiplier datapath.
- Sits directly upstream of the ripple-carry `adder` and drives it: one conditional add of the multiplicand into the high accumulator per cycle.
- Consumes the adder's `s`/`cout` and shifts them back into the accumulator.
- Start/done handshake; product is held until the next accepted start.

## Interface
- `WIDTH`, 8, operand width. The `adder` instance is sized to WIDTH; only 8 is verified.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: multiplicand; captured when start is accepted.
- `b` input WIDTH: multiplier; captured when start is accepted.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: single-cycle pulse while in DONE.
- `p` output 2*WIDTH: product register.

## Operation
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC → CALC while `cnt` < WIDTH-1; CALC → (ROUND | DONE) when `cnt` = WIDTH-1.
  - ROUND → DONE.
  - DONE → IDLE unconditionally.
- Start accept (IDLE & `start`): M←a, Q←b, ACC←0, cnt←0.
- Each CALC edge:
  - Adder inputs: a=ACC, b=(Q[0] ? M : 0), cin=0.
  - Update: {ACC,Q} ← {cout, s, Q[WIDTH-1:1]}; cnt increments.
  - The carry-out is never lost.
- Final CALC edge: p ← {ACC,Q} (exact product).
- Arithmetic rules:
  - Unsigned only.
  - Max product 0xFF×0xFF = 0xFE01 fits 2*WIDTH.
  - No overflow path.
- Reset values: `p`=0, `busy`=0, `done`=0, state=IDLE; all internal registers 0.
- Boundary behaviour:
  - `start` in CALC/ROUND/DONE is ignored and must not disturb M, Q or ACC. It is not queued.
  - `start` held high continuously: a new operation is accepted on the first IDLE edge, i.e. one cycle after `done`.
  - `rst` mid-operation aborts immediately to reset values. No `done` pulse is issued for the aborted operation.
  - `a`/`b` changing after acceptance has no effect.
  - Operand 0 still takes the full WIDTH cycles; there is no early termination.

## Timing
- The accepting edge is E0.
- CALC iterations occur on edges E1..E8 (WIDTH=8).
- Without rounding: `p` updates at E8; `done`=1 during the cycle E8–E9; IDLE at E9.
- With rounding: `p` updates at E9; `done`=1 during E9–E10; IDLE at E10.
- `busy` rises after E0 and falls at the same edge where `done` falls.
- Throughput: one product every WIDTH+2 cycles without rounding, WIDTH+3 with rounding.

## Configuration
- `MBM_ROUND_EN` defined:
  - ROUND state compiled in.
  - Adder reused with a=ACC, b=0, cin=Q[WIDTH-1].
  - p ← {s, WIDTH'b0}, i.e. the high byte is round-half-up of product/2^WIDTH.
  - Result = (P+128)>>8 ≤ 254; carry-out is provably 0.
- Undefined: no ROUND state; `p` is the exact 2*WIDTH product.

## Structure
- Shared package `mbm_pkg` holds:
  - State enum (IDLE, CALC, ROUND, DONE).
  - Default WIDTH.
  - Counter width $clog2(WIDTH).
  - ROUND_BIAS constant (1<<(WIDTH-1)).
- One sub-module: the existing `adder` (a, b, cin, s, cout), instantiated once and shared between CALC and ROUND via an input mux.

## Test plan
- Reset, then a=0x00, b=0x01, start → `done` 8 cycles after E0, p=0x0000; `busy` low after.
- a=0xFF, b=0xFF:
  - Without macro → p=0xFE01.
  - With macro → p=0xFE00 at E9.
- a=0x40, b=0x28 → p=0x0A00.
- a=0x80, b=0x01:
  - Without macro → p=0x0080.
  - With macro → p=0x0100 (rounding carries into the high byte).
- a=0x22, b=0x60 accepted; at E3 assert start with a=0xFF, b=0xFF → p=0x0CC0 (second request ignored); `done` pulses exactly once.
- a=0xA4, b=0x42; assert `rst` at E4 → p=0, `busy`=0, no `done`. Re-issue the same operands → p=0x2A48.
